jtag_dbg_bus_dr: RTL and testbench
==================================

Name: jtag_dbg_bus_dr

Overview:
- Debug data register and bus-request engine sitting directly downstream of the oversampled TAP stage (TCK sampled into the CPU clock, TAP state outputs qualified by a one-cycle TCK-rising strobe).
- Captures status and read data into a shift register, shifts it out on TDO, and on Update-DR decodes the shifted-in command into a single read or write request on a simple req/ack register bus.
- Runs entirely in the CPU clock domain; no TCK-clocked flops.

Parameters:
- ADDR_W, 8, bus address width.
- DATA_W, 32, bus data width.
- TIMEOUT, 255, max clk_i cycles req_o may wait for ack_i (1..2^TO_W-1).
- TO_W, 8, timeout counter width.

Ports:
- clk_i  in  1  CPU clock.
- rst_i  in  1  reset, asynchronous, active-high.
- tck_rise_i  in  1  one-cycle strobe: sampled TCK rising edge.
- debug_select_i  in  1  TAP debug instruction active.
- capture_dr_i  in  1  TAP in Capture-DR.
- shift_dr_i  in  1  TAP in Shift-DR.
- update_dr_i  in  1  TAP in Update-DR.
- tdi_i  in  1  sampled TDI.
- tdo_o  out  1  debug chain TDO, equals dr[0].
- req_o  out  1  bus request, level.
- we_o  out  1  1=write, 0=read; stable while req_o.
- addr_o  out  ADDR_W  bus address; stable while req_o.
- wdata_o  out  DATA_W  write data; stable while req_o.
- ack_i  in  1  bus acknowledge, one-cycle, only valid while req_o=1.
- rdata_i  in  DATA_W  read data, valid with ack_i.

Behaviour:
- DR_W = 1+ADDR_W+DATA_W (41 at defaults). Shift-in layout: dr[0]=rw (1=write), dr[ADDR_W:1]=addr, dr[DR_W-1:ADDR_W+1]=wdata.
- Actions occur only on a clk_i edge where tck_rise_i=1 and debug_select_i=1. Otherwise dr and status hold. Priority if multiple state inputs high: capture > shift > update.
- Capture: dr <= {rdata_q, zeros, rd_valid, timeout, overrun, busy}, status in bits [3:0], rdata_q in bits [DR_W-1:ADDR_W+1].
  - Same edge clears sticky overrun, timeout and rd_valid. A set event on that same edge wins; the flag stays 1.
- Shift: dr <= {tdi_i, dr[DR_W-1:1]}, LSB first. tdo_o = dr[0], registered.
- Update, in IDLE: latch we_o=dr[0], addr_o, wdata_o; next cycle req_o=1; FSM enters REQ.
- Update, in REQ: command dropped, overrun<=1, outputs unchanged.
- FSM states:
  - IDLE: req_o=0.
  - REQ: req_o=1, counter increments each cycle. Exits to IDLE on ack_i or on count==TIMEOUT.
  - On ack_i with we_o=0: rdata_q<=rdata_i and rd_valid<=1. On ack_i with we_o=1: rdata_q unchanged.
  - On timeout: timeout<=1, rdata_q unchanged, req_o drops the cycle after count==TIMEOUT.
  - ack_i arriving on the same cycle as count==TIMEOUT counts as ack, not timeout.
  - busy = (state==REQ).
- ack_i outside REQ is ignored.
- Reset (any time, including mid-request): all outputs and internal state 0 asynchronously; state=IDLE, dr=0, rdata_q=0, all flags 0. No request survives reset.
- Counter resets to 0 on REQ entry; never wraps (TIMEOUT < 2^TO_W).

Test Plan:
- Reset then capture+shift 41 bits -> tdo_o stream all 0; req_o=0.
- Shift in rw=1, addr=0x3C, wdata=0xDEADBEEF, then update; bus acks 3 cycles later -> req_o high exactly 3 cycles, we_o=1, addr_o=0x3C, wdata_o=0xDEADBEEF; next capture shows busy=0, rd_valid=0.
- Shift in read of addr=0x10; bus returns 0x12345678 with ack -> next capture shifts out status 4'b1000 then 0x12345678 LSB first; the capture after that shows rd_valid=0.
- Read with ack_i never asserted, TIMEOUT=255 -> req_o drops after 256 cycles; capture shows timeout=1, busy=0; the capture after that shows timeout=0.
- Second update while REQ pending -> addr_o/we_o unchanged, one request only; capture shows overrun=1, busy=1.
- Assert rst_i mid-REQ -> req_o=0 immediately (asynchronous); late ack_i after release ignored, rd_valid stays 0.

Source files
------------

// File: rtl/jtag_dbg_bus_dr_if.sv
// jtag_dbg_bus_dr_if: req/ack register bus between the debug DR engine and the target
interface jtag_dbg_bus_dr_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_o;
  logic              we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] wdata_o;
  logic              ack_i;
  logic [DATA_W-1:0] rdata_i;
  modport master (output req_o, we_o, addr_o, wdata_o, input ack_i, rdata_i);
  modport slave  (input req_o, we_o, addr_o, wdata_o, output ack_i, rdata_i);
endinterface

// File: rtl/jtag_dbg_bus_dr.sv
// jtag_dbg_bus_dr: debug data register that turns shifted-in commands into single req/ack bus accesses
module jtag_dbg_bus_dr #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tck_rise_i,
  input  logic              debug_select_i,
  input  logic              capture_dr_i,
  input  logic              shift_dr_i,
  input  logic              update_dr_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  jtag_dbg_bus_dr_if.master bus
);
  localparam int DR_W = 1 + ADDR_W + DATA_W;
  typedef enum logic {IDLE, REQ} state_e;
  state_e            state_q;
  logic [DR_W-1:0]   dr_q, dr_d;
  logic [DATA_W-1:0] rdata_q;
  logic [TO_W-1:0]   cnt_q;
  logic              rd_valid_q, timeout_q, overrun_q;
  logic              act, cap, shf, upd, busy, ack, to_hit;
  assign act    = tck_rise_i & debug_select_i;
  assign cap    = act & capture_dr_i;
  assign shf    = act & ~capture_dr_i & shift_dr_i;
  assign upd    = act & ~capture_dr_i & ~shift_dr_i & update_dr_i;
  assign busy   = state_q == REQ;
  assign ack    = busy & bus.ack_i;
  // ack on the final count wins over timeout
  assign to_hit = busy & ~bus.ack_i & (cnt_q == TO_W'(TIMEOUT));
  assign tdo_o  = dr_q[0];
  always_comb
    dr_d = cap ? {rdata_q, {(ADDR_W-3){1'b0}}, rd_valid_q, timeout_q, overrun_q, busy}
         : shf ? {tdi_i, dr_q[DR_W-1:1]}
         : dr_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q     <= IDLE;
      dr_q        <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      bus.req_o   <= 1'b0;
      bus.we_o    <= 1'b0;
      bus.addr_o  <= '0;
      bus.wdata_o <= '0;
    end else begin
      dr_q       <= dr_d;
      // sticky flags: a set on the capture edge beats the clear
      rd_valid_q <= (ack & ~bus.we_o) | (rd_valid_q & ~cap);
      timeout_q  <= to_hit | (timeout_q & ~cap);
      overrun_q  <= (upd & busy) | (overrun_q & ~cap);
      if (ack & ~bus.we_o) rdata_q <= bus.rdata_i;
      if (state_q == IDLE) begin
        if (upd) begin
          bus.we_o    <= dr_q[0];
          bus.addr_o  <= dr_q[ADDR_W:1];
          bus.wdata_o <= dr_q[DR_W-1:ADDR_W+1];
          bus.req_o   <= 1'b1;
          cnt_q       <= '0;
          state_q     <= REQ;
        end
      end else if (ack | to_hit) begin
        bus.req_o <= 1'b0;
        state_q   <= IDLE;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
endmodule

// File: tb/tb_jtag_dbg_bus_dr.sv
// tb_jtag_dbg_bus_dr: table-driven bench with a request scoreboard for the debug DR engine
module tb_jtag_dbg_bus_dr;
  logic clk = 1'b0, rst = 1'b1, tck = 1'b0, sel = 1'b1;
  logic cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0, tdo;
  int errors = 0, checks = 0;
  jtag_dbg_bus_dr_if bus ();
  jtag_dbg_bus_dr dut (
    .clk_i(clk), .rst_i(rst), .tck_rise_i(tck), .debug_select_i(sel),
    .capture_dr_i(cap), .shift_dr_i(shf), .update_dr_i(upd), .tdi_i(tdi),
    .tdo_o(tdo), .bus(bus.master)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic we; logic [7:0] addr; logic [31:0] wdata;} req_t;
  typedef struct {
    logic rw; logic [7:0] addr; logic [31:0] wdata;
    int dly; logic [31:0] rdata; int exp_len; logic [3:0] exp_st;
  } vec_t;
  req_t sbq[$];
  vec_t vt[7];
  logic [31:0] model_rd = '0;
  logic [40:0] out;
  int len;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic logic [40:0] cv(input logic [31:0] rd, input logic [3:0] st);
    return {rd, 5'b0, st};
  endfunction
  task automatic tap(input logic c, input logic s, input logic u, input logic t);
    @(negedge clk);
    cap = c; shf = s; upd = u; tdi = t; tck = 1'b1;
    @(negedge clk);
    tck = 1'b0; cap = 1'b0; shf = 1'b0; upd = 1'b0;
  endtask
  task automatic scan(input logic [40:0] din, output logic [40:0] dout);
    tap(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 41; i++) begin
      dout[i] = tdo;
      tap(1'b0, 1'b1, 1'b0, din[i]);
    end
  endtask
  task automatic cmd(input logic rw, input logic [7:0] a, input logic [31:0] d, output logic [40:0] dout);
    scan({d, a, rw}, dout);
    tap(1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic run_bus(input int dly, input logic [31:0] rd, output int n);
    req_t r;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.req_o) begin
        n++;
        if (n == 1) begin
          chk("sb_size", 64'(sbq.size()), 64'd1);
          if (sbq.size() > 0) begin
            r = sbq.pop_front();
            chk("req_fields", {bus.we_o, bus.addr_o, bus.wdata_o}, r);
          end
        end
        bus.ack_i = (dly > 0) && (n == dly);
        bus.rdata_i = rd;
      end else begin
        bus.ack_i = 1'b0;
        if (n > 0) break;
      end
      @(negedge clk);
    end
    bus.ack_i = 1'b0;
  endtask
  initial begin
    bus.ack_i = 1'b0;
    bus.rdata_i = '0;
    vt[0] = '{1'b1, 8'h3C, 32'hDEADBEEF, 3,   32'h0,        3,   4'b0000};
    vt[1] = '{1'b0, 8'h10, 32'h0,        2,   32'h12345678, 2,   4'b1000};
    vt[2] = '{1'b1, 8'hA5, 32'h0BADF00D, 1,   32'hFFFFFFFF, 1,   4'b0000};
    vt[3] = '{1'b0, 8'hFF, 32'h0,        5,   32'hCAFEF00D, 5,   4'b1000};
    vt[4] = '{1'b0, 8'h00, 32'h0,        256, 32'h5A5A5A5A, 256, 4'b1000};
    vt[5] = '{1'b0, 8'h77, 32'h0,        0,   32'h13579BDF, 256, 4'b0100};
    vt[6] = '{1'b1, 8'h01, 32'h00000001, 1,   32'h0,        1,   4'b0000};
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(bus.req_o), 64'd0);
    rst = 1'b0;
    scan(41'h1_2345_6789_A, out);
    chk("rst_tdo_stream", 64'(out), 64'd0);
    chk("rst_req_idle", 64'(bus.req_o), 64'd0);
    for (int i = 0; i < 7; i++) begin
      cmd(vt[i].rw, vt[i].addr, vt[i].wdata, out);
      chk($sformatf("pre_cap%0d", i), 64'(out), 64'(cv(model_rd, 4'b0000)));
      sbq.push_back({vt[i].rw, vt[i].addr, vt[i].wdata});
      run_bus(vt[i].dly, vt[i].rdata, len);
      chk($sformatf("req_len%0d", i), 64'(len), 64'(vt[i].exp_len));
      if (!vt[i].rw && vt[i].dly > 0 && vt[i].dly <= 256) model_rd = vt[i].rdata;
      scan(41'd0, out);
      chk($sformatf("post_cap%0d", i), 64'(out), 64'(cv(model_rd, vt[i].exp_st)));
    end
    // second update while a request is pending
    cmd(1'b0, 8'h20, 32'h0, out);
    sbq.push_back({1'b0, 8'h20, 32'h0});
    cmd(1'b1, 8'h99, 32'hFFFF0000, out);
    chk("ovr_busy_cap", 64'(out), 64'(cv(model_rd, 4'b0001)));
    chk("ovr_addr", 64'(bus.addr_o), 64'h20);
    chk("ovr_we", 64'(bus.we_o), 64'd0);
    scan(41'd0, out);
    chk("ovr_cap", 64'(out), 64'(cv(model_rd, 4'b0011)));
    run_bus(1, 32'h11112222, len);
    chk("ovr_len", 64'(len), 64'd1);
    model_rd = 32'h11112222;
    repeat (5) @(negedge clk);
    chk("ovr_single_req", 64'(bus.req_o), 64'd0);
    chk("ovr_sb_left", 64'(sbq.size()), 64'd0);
    scan(41'd0, out);
    chk("ovr_cap2", 64'(out), 64'(cv(model_rd, 4'b1000)));
    // asynchronous reset in the middle of a request
    cmd(1'b0, 8'h42, 32'h0, out);
    chk("rstm_pre_cap", 64'(out), 64'(cv(model_rd, 4'b0000)));
    @(negedge clk);
    chk("rstm_req_up", 64'(bus.req_o), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rstm_req_async", 64'(bus.req_o), 64'd0);
    chk("rstm_addr_async", 64'(bus.addr_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.ack_i = 1'b1;
    bus.rdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    bus.ack_i = 1'b0;
    chk("rstm_req_after", 64'(bus.req_o), 64'd0);
    scan(41'd0, out);
    chk("rstm_cap", 64'(out), 64'(cv(32'h0, 4'b0000)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
